// File: rtl/bp_stats_pkg.sv
// Shared constants for the branch-predictor statistics MMIO block:
// register offsets, CTRL/STATUS bit positions and counter width.
package bp_stats_pkg;

    localparam int CNT_W = 32;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_BR_LO  = 3'd2;
    localparam logic [2:0] OFF_BR_HI  = 3'd3;
    localparam logic [2:0] OFF_HIT_LO = 3'd4;
    localparam logic [2:0] OFF_HIT_HI = 3'd5;
    localparam logic [2:0] OFF_MIS_LO = 3'd6;
    localparam logic [2:0] OFF_MIS_HI = 3'd7;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_FRZ = 1;
    localparam int CTRL_CLR = 2;

    localparam int ST_BR_SAT  = 0;
    localparam int ST_HIT_SAT = 1;
    localparam int ST_MIS_SAT = 2;
    localparam int ST_FRZ     = 3;

endpackage

// File: rtl/bp_stats_mmio_if.sv
// CPU memory-mapped access bus: address, store data, strobes and
// combinational read data.
interface bp_stats_mmio_if;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        mm_we;
    logic        mm_re;
    logic [15:0] rdata;

    modport master (output addr, wdata, mm_we, mm_re, input rdata);
    modport slave  (input addr, wdata, mm_we, mm_re, output rdata);
endinterface

// File: rtl/sat_cnt32.sv
// 32-bit saturating event counter with synchronous clear and a sticky
// flag recording any increment attempted while already saturated.
module sat_cnt32
    import bp_stats_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             en,
    output logic [CNT_W-1:0] q,
    output logic             sat
);

    logic [CNT_W-1:0] q_q, q_d;
    logic             sat_q, sat_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        q_d   = q_q;
        sat_d = sat_q;
        if (clr) begin
            q_d   = '0;
            sat_d = 1'b0;
        end else if (inc && en) begin
            if (&q_q) sat_d = 1'b1;
            else      q_d   = q_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            sat_q <= sat_d;
        end
    end

    assign q   = q_q;
    assign sat = sat_q;

endmodule

// File: rtl/bp_stats_mmio.sv
// Branch-predictor statistics block: three saturating counters behind an
// 8-word MMIO window, with a LO-read shadow giving coherent 32-bit reads.
module bp_stats_mmio
    import bp_stats_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hC010
) (
    input  logic              clk,
    input  logic              rst,
    bp_stats_mmio_if.slave    bus,
    input  logic              inc_br_cnt,
    input  logic              inc_hit_cnt,
    input  logic              inc_mispr_cnt
);

    logic        sel, ctrl_wr, clr, cnt_en;
    logic [2:0]  off;
    logic        en_q, en_d, frz_q, frz_d;
    logic [15:0] shadow_q [3];
    logic [15:0] shadow_d [3];
    logic [CNT_W-1:0] cnt [3];
    logic [2:0]  sat;
    logic        unused_wdata;

    assign sel          = (bus.addr[15:3] == BASE_ADDR[15:3]);
    assign off          = bus.addr[2:0];
    assign ctrl_wr      = sel && bus.mm_we && (off == OFF_CTRL);
    assign clr          = ctrl_wr && bus.wdata[CTRL_CLR];
    assign cnt_en       = en_q && !frz_q;
    assign unused_wdata = ^bus.wdata[15:3];

    sat_cnt32 u_br  (.clk, .rst, .clr, .inc(inc_br_cnt),    .en(cnt_en), .q(cnt[0]), .sat(sat[0]));
    sat_cnt32 u_hit (.clk, .rst, .clr, .inc(inc_hit_cnt),   .en(cnt_en), .q(cnt[1]), .sat(sat[1]));
    sat_cnt32 u_mis (.clk, .rst, .clr, .inc(inc_mispr_cnt), .en(cnt_en), .q(cnt[2]), .sat(sat[2]));

    always_comb begin
        en_d     = en_q;
        frz_d    = frz_q;
        shadow_d = shadow_q;
        if (ctrl_wr) begin
            en_d  = bus.wdata[CTRL_EN];
            frz_d = bus.wdata[CTRL_FRZ];
        end
        // A LO read captures the high half so the following HI read is coherent.
        if (clr) begin
            shadow_d = '{default: '0};
        end else if (sel && bus.mm_re) begin
            case (off)
                OFF_BR_LO:  shadow_d[0] = cnt[0][31:16];
                OFF_HIT_LO: shadow_d[1] = cnt[1][31:16];
                OFF_MIS_LO: shadow_d[2] = cnt[2][31:16];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b1;
            frz_q    <= 1'b0;
            // NOTE: the shadow array is only three words, so it is reset explicitly like any register.
            shadow_q <= '{default: '0};
        end else begin
            en_q     <= en_d;
            frz_q    <= frz_d;
            shadow_q <= shadow_d;
        end
    end

    // Reads reflect pre-edge state, so a same-cycle write is not visible yet.
    always_comb begin
        bus.rdata = '0;
        if (sel && bus.mm_re) begin
            case (off)
                OFF_CTRL: begin
                    bus.rdata[CTRL_EN]  = en_q;
                    bus.rdata[CTRL_FRZ] = frz_q;
                end
                OFF_STATUS: begin
                    bus.rdata[ST_BR_SAT]  = sat[0];
                    bus.rdata[ST_HIT_SAT] = sat[1];
                    bus.rdata[ST_MIS_SAT] = sat[2];
                    bus.rdata[ST_FRZ]     = frz_q;
                end
                OFF_BR_LO:  bus.rdata = cnt[0][15:0];
                OFF_BR_HI:  bus.rdata = shadow_q[0];
                OFF_HIT_LO: bus.rdata = cnt[1][15:0];
                OFF_HIT_HI: bus.rdata = shadow_q[1];
                OFF_MIS_LO: bus.rdata = cnt[2][15:0];
                OFF_MIS_HI: bus.rdata = shadow_q[2];
                default:    bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_stats_mmio.sv
// Self-checking bench for bp_stats_mmio: a vector table for the basic map,
// then hand-written sequences for carry coherence, saturation, freeze and reset.
module tb_bp_stats_mmio;
    import bp_stats_pkg::*;

    localparam logic [15:0] BASE = 16'hC010;

    logic clk = 1'b0;
    logic rst;
    logic inc_br_cnt, inc_hit_cnt, inc_mispr_cnt;

    bp_stats_mmio_if bus ();

    bp_stats_mmio #(.BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .inc_br_cnt    (inc_br_cnt),
        .inc_hit_cnt   (inc_hit_cnt),
        .inc_mispr_cnt (inc_mispr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        re;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  inc;
        bit          chk;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    vec_t tbl [$];
    sb_t  sb_q [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [15:0] a(input logic [2:0] off);
        return {BASE[15:3], off};
    endfunction

    function automatic vec_t mk(input string n, input logic re, input logic we,
                                input logic [15:0] ad, input logic [15:0] wd,
                                input logic [2:0] inc, input bit chk, input logic [15:0] exp);
        vec_t v;
        v.name = n; v.re = re; v.we = we; v.addr = ad; v.wdata = wd;
        v.inc = inc; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: rdata=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock of stimulus; an expected read value is queued when driven
    // and compared once the combinational read data has settled.
    task automatic step(input logic r, input logic re, input logic we,
                        input logic [15:0] ad, input logic [15:0] wd, input logic [2:0] inc,
                        input bit chk, input logic [15:0] exp, input string name);
        sb_t e;
        @(negedge clk);
        rst = r; bus.mm_re = re; bus.mm_we = we; bus.addr = ad; bus.wdata = wd;
        inc_br_cnt = inc[0]; inc_hit_cnt = inc[1]; inc_mispr_cnt = inc[2];
        if (chk) begin
            e.name = name; e.exp = exp;
            sb_q.push_back(e);
        end
        #1;
        if (chk) begin
            e = sb_q.pop_front();
            check(e.name, bus.rdata, e.exp);
        end
    endtask

    task automatic rd(input logic [2:0] off, input logic [15:0] exp, input string name);
        step(1'b0, 1'b1, 1'b0, a(off), 16'h0, 3'b000, 1'b1, exp, name);
    endtask

    task automatic wr_ctrl(input logic [15:0] wd, input logic [2:0] inc);
        step(1'b0, 1'b0, 1'b1, a(OFF_CTRL), wd, inc, 1'b0, 16'h0, "wr_ctrl");
    endtask

    task automatic pulse(input logic [2:0] inc);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, inc, 1'b0, 16'h0, "pulse");
    endtask

    // Idle one edge, then preload a counter directly to reach far-off values.
    task automatic deposit(input int which, input logic [31:0] v);
        pulse(3'b000);
        @(negedge clk);
        case (which)
            0:       dut.u_br.q_q  = v;
            1:       dut.u_hit.q_q = v;
            default: dut.u_mis.q_q = v;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t expected=done", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; bus.mm_re = 1'b0; bus.mm_we = 1'b0; bus.addr = '0; bus.wdata = '0;
        inc_br_cnt = 1'b0; inc_hit_cnt = 1'b0; inc_mispr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'b000, 1'b1, 16'h0000, "rdata_after_reset");

        tbl.push_back(mk("ctrl_reset",   1, 0, a(OFF_CTRL),   16'h0,    3'b000, 1, 16'h0001));
        tbl.push_back(mk("status_reset", 1, 0, a(OFF_STATUS), 16'h0,    3'b000, 1, 16'h0000));
        tbl.push_back(mk("br_lo_reset",  1, 0, a(OFF_BR_LO),  16'h0,    3'b000, 1, 16'h0000));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk("inc_br", 0, 0, 16'h0, 16'h0, 3'b001, 0, 16'h0));
        tbl.push_back(mk("br_lo_5",      1, 0, a(OFF_BR_LO),  16'h0,    3'b000, 1, 16'h0005));
        tbl.push_back(mk("br_hi_5",      1, 0, a(OFF_BR_HI),  16'h0,    3'b000, 1, 16'h0000));
        tbl.push_back(mk("status_5",     1, 0, a(OFF_STATUS), 16'h0,    3'b000, 1, 16'h0000));
        tbl.push_back(mk("inc_all",      0, 0, 16'h0,         16'h0,    3'b111, 0, 16'h0));
        tbl.push_back(mk("hit_lo_1",     1, 0, a(OFF_HIT_LO), 16'h0,    3'b000, 1, 16'h0001));
        tbl.push_back(mk("mis_lo_1",     1, 0, a(OFF_MIS_LO), 16'h0,    3'b000, 1, 16'h0001));
        tbl.push_back(mk("br_lo_6",      1, 0, a(OFF_BR_LO),  16'h0,    3'b000, 1, 16'h0006));
        tbl.push_back(mk("unsel_read",   1, 0, BASE + 16'd8,  16'h0,    3'b000, 1, 16'h0000));
        tbl.push_back(mk("no_re_zero",   0, 0, a(OFF_BR_LO),  16'h0,    3'b000, 1, 16'h0000));
        tbl.push_back(mk("wr_br_hi",     0, 1, a(OFF_BR_HI),  16'hFFFF, 3'b000, 0, 16'h0));
        tbl.push_back(mk("br_lo_ro",     1, 0, a(OFF_BR_LO),  16'h0,    3'b000, 1, 16'h0006));
        tbl.push_back(mk("br_hi_ro",     1, 0, a(OFF_BR_HI),  16'h0,    3'b000, 1, 16'h0000));
        tbl.push_back(mk("rw_ctrl_pre",  1, 1, a(OFF_CTRL),   16'h0000, 3'b000, 1, 16'h0001));
        tbl.push_back(mk("ctrl_en0",     1, 0, a(OFF_CTRL),   16'h0,    3'b000, 1, 16'h0000));
        tbl.push_back(mk("inc_br_off",   0, 0, 16'h0,         16'h0,    3'b001, 0, 16'h0));
        tbl.push_back(mk("br_lo_en0",    1, 0, a(OFF_BR_LO),  16'h0,    3'b000, 1, 16'h0006));
        tbl.push_back(mk("wr_ctrl_en1",  0, 1, a(OFF_CTRL),   16'h0001, 3'b000, 0, 16'h0));
        tbl.push_back(mk("unsel_write",  0, 1, BASE + 16'd8,  16'h0000, 3'b000, 0, 16'h0));
        tbl.push_back(mk("ctrl_unsel",   1, 0, a(OFF_CTRL),   16'h0,    3'b000, 1, 16'h0001));

        foreach (tbl[i])
            step(1'b0, tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].inc,
                 tbl[i].chk, tbl[i].exp, tbl[i].name);

        // Coherent LO/HI across a low-half carry.
        deposit(0, 32'h0000_FFFF);
        rd(OFF_BR_LO, 16'hFFFF, "carry_lo");
        pulse(3'b001);
        rd(OFF_BR_HI, 16'h0000, "carry_hi_shadow");
        rd(OFF_BR_LO, 16'h0000, "carry_lo_after");
        rd(OFF_BR_HI, 16'h0001, "carry_hi_after");

        // Stalled LO read re-latches each cycle; the last latch stands.
        deposit(0, 32'h0000_FFFE);
        step(1'b0, 1'b1, 1'b0, a(OFF_BR_LO), 16'h0, 3'b001, 1'b1, 16'hFFFE, "stall_lo0");
        step(1'b0, 1'b1, 1'b0, a(OFF_BR_LO), 16'h0, 3'b001, 1'b1, 16'hFFFF, "stall_lo1");
        step(1'b0, 1'b1, 1'b0, a(OFF_BR_LO), 16'h0, 3'b001, 1'b1, 16'h0000, "stall_lo2");
        rd(OFF_BR_HI, 16'h0001, "stall_hi");

        // Saturation and clear.
        deposit(0, 32'hFFFF_FFFE);
        repeat (3) pulse(3'b001);
        rd(OFF_BR_LO,  16'hFFFF, "sat_br_lo");
        rd(OFF_BR_HI,  16'hFFFF, "sat_br_hi");
        rd(OFF_STATUS, 16'h0001, "sat_status");
        wr_ctrl(16'h0005, 3'b000);
        rd(OFF_BR_LO,  16'h0000, "clr_br_lo");
        rd(OFF_BR_HI,  16'h0000, "clr_br_hi");
        rd(OFF_STATUS, 16'h0000, "clr_status");
        rd(OFF_CTRL,   16'h0001, "clr_ctrl");
        rd(OFF_HIT_LO, 16'h0000, "clr_hit_lo");

        deposit(1, 32'hFFFF_FFFF);
        deposit(2, 32'hFFFF_FFFF);
        pulse(3'b110);
        rd(OFF_STATUS, 16'h0006, "sat_hit_mis");
        wr_ctrl(16'h0005, 3'b000);

        // Freeze blocks all increments.
        wr_ctrl(16'h0003, 3'b000);
        repeat (4) pulse(3'b111);
        rd(OFF_BR_LO,  16'h0000, "frz_br");
        rd(OFF_HIT_LO, 16'h0000, "frz_hit");
        rd(OFF_MIS_LO, 16'h0000, "frz_mis");
        rd(OFF_STATUS, 16'h0008, "frz_status");
        rd(OFF_CTRL,   16'h0003, "frz_ctrl");
        wr_ctrl(16'h0001, 3'b000);

        // Clear beats a same-edge increment.
        repeat (2) pulse(3'b010);
        rd(OFF_HIT_LO, 16'h0002, "hit_lo_2");
        wr_ctrl(16'h0005, 3'b010);
        rd(OFF_HIT_LO, 16'h0000, "clr_vs_inc");

        // Reset in the middle of a LO/HI pair.
        wr_ctrl(16'h0000, 3'b000);
        deposit(0, 32'h0003_0004);
        rd(OFF_BR_LO, 16'h0004, "pre_rst_lo");
        step(1'b1, 1'b1, 1'b1, a(OFF_CTRL), 16'h0002, 3'b111, 1'b0, 16'h0, "rst_pulse");
        rd(OFF_BR_HI,  16'h0000, "rst_hi");
        rd(OFF_CTRL,   16'h0001, "rst_ctrl");
        rd(OFF_BR_LO,  16'h0000, "rst_br_lo");
        rd(OFF_STATUS, 16'h0000, "rst_status");
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'b000, 1'b1, 16'h0000, "rst_idle_rdata");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_stats_mmio.md
BP_STATS_MMIO -- requirements
Module: bp_stats_mmio

Interface
REQ-001 Parameter: BASE_ADDR, default 16'hC010, word base of the 8-register window; SHALL have BASE_ADDR[2:0]=0 and BASE_ADDR[15:13]!=0 (external region).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 addr  input  16  CPU memory-mapped address, valid while mm_re/mm_we high.
REQ-005 wdata  input  16  CPU store data.
REQ-006 mm_we  input  1  external write strobe, one write per cycle high.
REQ-007 mm_re  input  1  external read strobe.
REQ-008 rdata  output  16  read data, combinational from addr/state.
REQ-009 inc_br_cnt  input  1  one branch resolved this cycle.
REQ-010 inc_hit_cnt  input  1  one BTB hit this cycle.
REQ-011 inc_mispr_cnt  input  1  one misprediction this cycle.

Function
REQ-012 Select = addr[15:3]==BASE_ADDR[15:3]; offset = addr[2:0]; unselected accesses SHALL have no effect and rdata SHALL be 16'h0000.
REQ-013 Map: 0 CTRL (bit0 EN, bit1 FRZ, bit2 CLR write-only), 1 STATUS (bit0 BR_SAT, bit1 HIT_SAT, bit2 MIS_SAT, bit3 = FRZ), 2/3 BR lo/hi, 4/5 HIT lo/hi, 6/7 MIS lo/hi.
REQ-014 Three 32-bit counters; each increments by 1 on the edge where its inc input is high and EN=1 and FRZ=0; the three counters are independent, so simultaneous incs all count.
REQ-015 Counters SHALL saturate at 32'hFFFF_FFFF; the increment attempted at saturation sets the matching sticky STATUS SAT bit.
REQ-016 Write to CTRL: EN, FRZ <= wdata[1:0] on the next edge; if wdata[2]=1, all counters, SAT bits and shadows are cleared on that edge; CLR reads back 0.
REQ-017 Clear and increment on the same edge: clear wins, counter = 0.
REQ-018 Writes to offsets 1-7 SHALL be ignored.
REQ-019 Read latency zero: rdata valid in the same cycle mm_re is high, because the CPU consumes it combinationally.
REQ-020 Reading a LO offset returns the live low half and, at that edge, latches the live high half into that counter's 16-bit shadow; reading the HI offset returns the shadow. A LO-then-HI sequence is therefore coherent even across a low-half carry.
REQ-021 A LO read held for several cycles (pipeline stall) re-latches the shadow each cycle; the value from the last cycle is the one that stands.
REQ-022 mm_re and mm_we both high at the same select: the write is performed, and rdata returns the pre-write value.
REQ-023 CTRL read returns {13'b0, 1'b0, FRZ, EN}; STATUS read returns {12'b0, FRZ, MIS_SAT, HIT_SAT, BR_SAT}.

Reset
REQ-024 When rst is high at an edge: counters = 0, shadows = 0, SAT bits = 0, EN = 1, FRZ = 0.
REQ-025 rst overrides any simultaneous access or increment, and reset mid-operation discards pending shadow data.
REQ-026 rdata SHALL be 16'h0000 after reset until the next selected read.

Structure
REQ-027 Package bp_stats_pkg holds the offset constants (OFF_CTRL..OFF_MIS_HI), CTRL/STATUS bit indices, and CNT_W=32.
REQ-028 One sub-module sat_cnt32 (clk, rst, clr, inc, en, q[31:0], sat), instantiated three times.
REQ-029 Target size is 120-400 lines of RTL total.

Verification
REQ-030 Reset, then pulse inc_br_cnt 5 cycles -> BR_LO=5, BR_HI=0, STATUS=0.
REQ-031 Force BR=32'h0000_FFFF; read LO (returns FFFF, shadow=0000); one inc; read HI -> returns 0000, not 0001.
REQ-032 BR=32'hFFFF_FFFE, 3 incs -> BR=FFFF_FFFF and STATUS bit0=1; write CTRL=16'h0005 -> BR=0, STATUS=0, EN=1.
REQ-033 Write CTRL=16'h0003 (FRZ), pulse all three incs 4 cycles -> counters unchanged; STATUS read = 16'h0008.
REQ-034 CLR write on the same edge as inc_hit_cnt -> HIT=0; access to BASE_ADDR+8 -> rdata=0, no state change.
REQ-035 Assert rst during a LO-then-HI read pair -> HI read returns 0000, EN=1.
